// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its two requesters and the shared 16-bit ALU.
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
);
   logic             req0, req1;
   logic [OPW-1:0]   op0, op1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             gnt0, gnt1;
   logic             done0, done1;
   logic [WIDTH-1:0] result;
   logic             res_zero, res_equal;
   logic             busy;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_a, alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_zero, alu_equal;

   modport slave (
      input  req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero, alu_equal,
      output gnt0, gnt1, done0, done1, result, res_zero, res_equal, busy,
             alu_op, alu_a, alu_b
   );

   modport master (
      output req0, req1, op0, op1, a0, b0, a1, b1, alu_out, alu_zero, alu_equal,
      input  gnt0, gnt1, done0, done1, result, res_zero, res_equal, busy,
             alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer for the shared ALU with one-clock registered latency.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | sample REQ0/REQ1, grant a winner and load the ALU drive registers
// EXEC  | ALU registers its result on the edge leaving this state
// CAPT  | capture ALU OUT/ZERO/EQUAL and pulse DONE to the owner
module alu_arbiter #(
   parameter int WIDTH = 16,
   parameter int OPW   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      CAPT = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             owner_q, owner_d;
   logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             res_zero_q, res_zero_d, res_equal_q, res_equal_d;
   logic             busy_q, busy_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic             win;

   // win is only meaningful when at least one request is present
   always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = ~bus.req0;
`else
      win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      result_d    = result_q;
      res_zero_d  = res_zero_q;
      res_equal_d = res_equal_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               owner_d  = win;
               last_d   = win;
               gnt0_d   = ~win;
               gnt1_d   = win;
               alu_op_d = win ? bus.op1 : bus.op0;
               alu_a_d  = win ? bus.a1  : bus.a0;
               alu_b_d  = win ? bus.b1  : bus.b0;
               state_d  = EXEC;
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            result_d    = bus.alu_out;
            res_zero_d  = bus.alu_zero;
            res_equal_d = bus.alu_equal;
            done0_d     = ~owner_q;
            done1_d     = owner_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         result_q    <= '0;
         res_zero_q  <= 1'b0;
         res_equal_q <= 1'b0;
         busy_q      <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         result_q    <= result_d;
         res_zero_q  <= res_zero_d;
         res_equal_q <= res_equal_d;
         busy_q      <= busy_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.result    = result_q;
   assign bus.res_zero  = res_zero_q;
   assign bus.res_equal = res_equal_q;
   assign bus.busy      = busy_q;
   assign bus.alu_op    = alu_op_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   alu_arbiter_if #(.WIDTH(16), .OPW(3)) bus ();

   alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ALU model: op 0 add, 1 sub, 2 and, 3 or, others xor; one-clock registered latency
   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         default: return a ^ b;
      endcase
   endfunction

   always @(posedge clk) begin
      bus.alu_out   <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
      bus.alu_zero  <= (alu_f(bus.alu_op, bus.alu_a, bus.alu_b) == 16'd0);
      bus.alu_equal <= (bus.alu_a == bus.alu_b);
   end

   always @(negedge clk) begin
      n_chk++;
      if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
         n_fail++;
         $display("FAIL gnt_exclusive: gnt0=%0b gnt1=%0b required not both 1", bus.gnt0, bus.gnt1);
      end
      n_chk++;
      if ((bus.done0 & bus.done1) !== 1'b0) begin
         n_fail++;
         $display("FAIL done_exclusive: done0=%0b done1=%0b required not both 1", bus.done0, bus.done1);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
      bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
      step(); step();
      n_chk++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.res_zero, bus.res_equal} !== 7'd0) begin
         n_fail++; $display("FAIL reset_flags: got %b required 0000000",
            {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.res_zero, bus.res_equal}); end
      n_chk++; if (bus.result !== 16'd0) begin n_fail++; $display("FAIL reset_result: got %0h required 0", bus.result); end
      n_chk++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 35'd0) begin
         n_fail++; $display("FAIL reset_alu: got %0h required 0", {bus.alu_op, bus.alu_a, bus.alu_b}); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_contention();
      logic exp_w;
      bus.op0 = 0; bus.a0 = 16'd1; bus.b0 = 16'd1;
      bus.op1 = 0; bus.a1 = 16'd2; bus.b1 = 16'd2;
      bus.req0 = 1; bus.req1 = 1;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_w = 1'b0;
`else
         exp_w = k[0];
`endif
         step();
         n_chk++; if ({bus.gnt0, bus.gnt1} !== {~exp_w, exp_w}) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b required %b", k, {bus.gnt0, bus.gnt1}, {~exp_w, exp_w}); end
         step();
         n_chk++; if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b001) begin
            n_fail++; $display("FAIL rr_exec[%0d]: gnt/busy got %b required 001", k, {bus.gnt0, bus.gnt1, bus.busy}); end
         step();
         n_chk++; if ({bus.done0, bus.done1, bus.busy} !== {~exp_w, exp_w, 1'b0}) begin
            n_fail++; $display("FAIL rr_done[%0d]: done/busy got %b required %b", k,
               {bus.done0, bus.done1, bus.busy}, {~exp_w, exp_w, 1'b0}); end
         n_chk++; if (bus.result !== (exp_w ? 16'd4 : 16'd2)) begin
            n_fail++; $display("FAIL rr_result[%0d]: got %0d required %0d", k, bus.result, exp_w ? 4 : 2); end
         if (k == 3) begin bus.req0 = 0; bus.req1 = 0; end
      end
      step();
      n_chk++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'd0) begin
         n_fail++; $display("FAIL rr_quiet: got %b required 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}); end
   endtask

   task automatic test_single_add();
      bus.req0 = 1; bus.op0 = 0; bus.a0 = 16'd4; bus.b0 = 16'd4;
      step();
      n_chk++; if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
         n_fail++; $display("FAIL add_gnt: gnt0/gnt1/busy got %b required 101", {bus.gnt0, bus.gnt1, bus.busy}); end
      n_chk++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {3'd0, 16'd4, 16'd4}) begin
         n_fail++; $display("FAIL add_drive: got %0h required %0h", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'd0, 16'd4, 16'd4}); end
      bus.req0 = 0;
      step();
      n_chk++; if ({bus.gnt0, bus.done0, bus.busy} !== 3'b001) begin
         n_fail++; $display("FAIL add_exec: gnt0/done0/busy got %b required 001", {bus.gnt0, bus.done0, bus.busy}); end
      step();
      n_chk++; if ({bus.done0, bus.done1, bus.busy} !== 3'b100) begin
         n_fail++; $display("FAIL add_done: done0/done1/busy got %b required 100", {bus.done0, bus.done1, bus.busy}); end
      n_chk++; if ({bus.result, bus.res_zero, bus.res_equal} !== {16'd8, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL add_result: result=%0d zero=%0b equal=%0b required 8 0 1", bus.result, bus.res_zero, bus.res_equal); end
      step();
      n_chk++; if (bus.done0 !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: done0 got %0b required 0", bus.done0); end
   endtask

   task automatic test_zero_flag();
      bus.req1 = 1; bus.op1 = 0; bus.a1 = 16'd0; bus.b1 = 16'd0;
      step();
      n_chk++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
         n_fail++; $display("FAIL zero_gnt: got %b required 01", {bus.gnt0, bus.gnt1}); end
      bus.req1 = 0;
      step(); step();
      n_chk++; if ({bus.done0, bus.done1, bus.result, bus.res_zero, bus.res_equal} !== {2'b01, 16'd0, 2'b11}) begin
         n_fail++; $display("FAIL zero_result: done=%b result=%0d zero=%0b equal=%0b required 01 0 1 1",
            {bus.done0, bus.done1}, bus.result, bus.res_zero, bus.res_equal); end
      step();
   endtask

   task automatic test_wrap();
      bus.req0 = 1; bus.op0 = 0; bus.a0 = 16'hFFFF; bus.b0 = 16'h0001;
      step();
      bus.req0 = 0;
      step(); step();
      n_chk++; if ({bus.done0, bus.result, bus.res_zero, bus.res_equal} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL wrap_result: done0=%0b result=%0h zero=%0b equal=%0b required 1 0 1 0",
            bus.done0, bus.result, bus.res_zero, bus.res_equal); end
      step();
   endtask

   task automatic test_operand_change();
      bus.req0 = 1; bus.op0 = 0; bus.a0 = 16'd6; bus.b0 = 16'd4;
      step();
      n_chk++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL opchg_gnt: gnt0 got %0b required 1", bus.gnt0); end
      bus.a0 = 16'd5; bus.req0 = 0;
      step();
      n_chk++; if (bus.alu_a !== 16'd6) begin n_fail++; $display("FAIL opchg_exec_a: alu_a got %0d required 6", bus.alu_a); end
      step();
      n_chk++; if (bus.alu_a !== 16'd6) begin n_fail++; $display("FAIL opchg_capt_a: alu_a got %0d required 6", bus.alu_a); end
      n_chk++; if ({bus.done0, bus.result} !== {1'b1, 16'd10}) begin
         n_fail++; $display("FAIL opchg_result: done0=%0b result=%0d required 1 10", bus.done0, bus.result); end
   endtask

   task automatic test_idle_stability();
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if ({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 5'd0) bad++;
         if ({bus.result, bus.alu_op, bus.alu_a, bus.alu_b} !== {16'd10, 3'd0, 16'd6, 16'd4}) bad++;
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL idle_hold: %0d bad idle samples, required 0", bad); end
   endtask

   task automatic test_reset_mid_op();
      int bad;
      bus.req0 = 1; bus.op0 = 0; bus.a0 = 16'd3; bus.b0 = 16'd3;
      step();
      n_chk++; if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: gnt0 got %0b required 1", bus.gnt0); end
      rst_n = 1'b0;
      #1;
      n_chk++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.res_zero, bus.res_equal} !== 7'd0) begin
         n_fail++; $display("FAIL rmid_flags: got %b required 0000000",
            {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.res_zero, bus.res_equal}); end
      n_chk++; if ({bus.result, bus.alu_op, bus.alu_a, bus.alu_b} !== 51'd0) begin
         n_fail++; $display("FAIL rmid_data: got %0h required 0", {bus.result, bus.alu_op, bus.alu_a, bus.alu_b}); end
      bus.req0 = 0;
      step(); step();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if ({bus.done0, bus.done1, bus.gnt0, bus.gnt1} !== 4'd0) bad++;
      end
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_no_done: %0d bad samples, required 0", bad); end
      bus.req1 = 1; bus.op1 = 0; bus.a1 = 16'd7; bus.b1 = 16'd1;
      step();
      n_chk++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
         n_fail++; $display("FAIL rmid_req1_gnt: got %b required 01", {bus.gnt0, bus.gnt1}); end
      step(); step();
      n_chk++; if ({bus.done1, bus.result} !== {1'b1, 16'd8}) begin
         n_fail++; $display("FAIL rmid_req1_done: done1=%0b result=%0d required 1 8", bus.done1, bus.result); end
      bus.req0 = 1; bus.op0 = 0; bus.a0 = 16'd2; bus.b0 = 16'd5;
      step();
      n_chk++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
         n_fail++; $display("FAIL rmid_tie_gnt: got %b required 10", {bus.gnt0, bus.gnt1}); end
      bus.req0 = 0; bus.req1 = 0;
      step(); step();
      n_chk++; if ({bus.done0, bus.result, bus.res_equal} !== {1'b1, 16'd7, 1'b0}) begin
         n_fail++; $display("FAIL rmid_tie_done: done0=%0b result=%0d equal=%0b required 1 7 0", bus.done0, bus.result, bus.res_equal); end
      step();
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      test_reset();
      test_contention();
      test_single_add();
      test_zero_flag();
      test_wrap();
      test_operand_change();
      test_idle_stability();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
